wb_retire_unit: RTL and testbench
=================================

# wb_retire_unit

In-order writeback/retirement buffer for the 2-way superscalar core. It sits between the two execution/memory completion lanes and the dual-write-port register file. It accepts results out of order, tagged by program-order slot, and drives the register file's two write ports (wen1/rd_addr1/write_data1 = older, wen2/... = younger). It retires at most two instructions per cycle, strictly in program order.

## Interface
- DATA_W, 64, result/register data width
- DEPTH, 8, buffer entries (power of 2, ≥4); TAG_W = log2(DEPTH)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; discard all entries, no writes issued
- alloc_req  in  2  number of slots requested by issue this cycle (0,1,2; 3 illegal)
- alloc_ready  out  1  high when ≥2 entries free (registered occupancy)
- alloc_tag0 / alloc_tag1  out  TAG_W  tags assigned to older/younger allocated instruction (tail, tail+1 mod DEPTH)
- comp_valid1 / comp_valid2  in  1  completion lane valid
- comp_tag1 / comp_tag2  in  TAG_W  slot being completed
- comp_wr1 / comp_wr2  in  1  instruction writes a destination register
- comp_rd1 / comp_rd2  in  5  destination register
- comp_data1 / comp_data2  in  DATA_W  result
- wen1, wen2  out  1  register-file write enables (older/younger)
- rd_addr1, rd_addr2  out  5  write addresses
- write_data1, write_data2  out  DATA_W  write data
- retire_cnt  out  2  instructions retired this cycle (0–2)
- empty  out  1  occupancy == 0

## Operation
- Circular buffer with head and tail pointers (TAG_W bits) plus occupancy count (TAG_W+1 bits). Each entry holds busy, done, wr, rd, data.
- Allocation: alloc_req is honoured only when alloc_ready=1; otherwise ignored. On grant, tail advances by alloc_req; entries are set busy=1, done=0.
- Completion: for comp_validN with busy[tag]=1, set done=1 and latch wr/rd/data. Completion to a non-busy tag is ignored. If both lanes carry the same tag, lane 1 wins.
- Retirement: head entry retires if busy&done; head+1 also retires if head retires and head+1 is busy&done. Retired entries are cleared and head advances by retire_cnt.
- Write-port mapping: older retiree → port 1, younger → port 2. wenN = retiring & wr & (rd≠0). Writes to x0 are suppressed; the rd/data fields still show the values.
- Same-rd hazard: if both retire with wr=1 and equal nonzero rd, wen1 is forced 0 and only port 2 (younger) writes.
- Occupancy_next = occ + granted_alloc − retire_cnt. Simultaneous alloc and retire in one cycle is legal. Freed entries become allocatable the next cycle.
- Flush: clears busy/done of all entries and sets head=tail=occ=0. Write outputs are 0 the following cycle. Flush has priority over alloc, completion, and retire in the same cycle.

## Timing
- All outputs are registered except alloc_ready, alloc_tag0/1, and empty, which are decoded from registered state.
- Reset values: wen1=wen2=0, rd_addr1/2=0, write_data1/2=0, retire_cnt=0, head=tail=occ=0, alloc_ready=1, alloc_tag0=0, alloc_tag1=1, empty=1.
- Latency:
  - Completion presented in cycle N → done visible in N+1 → wen asserted in cycle N+2 if the entry is at head (or head+1 with head retiring).
  - Allocation in cycle N → tag completable from cycle N+1.
- wenN is a single-cycle pulse per retired instruction. It is never held across cycles for the same entry.
- Pointer wrap: head/tail wrap DEPTH−1 → 0. Full = occ==DEPTH; with alloc_ready requiring ≥2 free, a full buffer never accepts allocation.
- Reset asserted mid-operation: all state and outputs go to reset values immediately (asynchronous). In-flight results are lost and no write pulse occurs.

## Test plan
- Reset then alloc_req=2 → tags 0,1. Complete tag1 (rd=5, data=0xAA), then tag0 (rd=6, data=0xBB) a cycle later → no write until tag0 is done. Then one cycle with wen1=1 rd_addr1=6 data 0xBB, wen2=1 rd_addr2=5 data 0xAA, retire_cnt=2.
- Same-rd: tags 0,1 both rd=7 (data 1, 2), completed in the same cycle → two cycles later wen1=0, wen2=1, rd_addr2=7, write_data2=2.
- x0 and non-writing instructions: rd=0 with wr=1, and wr=0 → retire_cnt=2, wen1=wen2=0.
- Fill and wrap: allocate 8 with no completions → alloc_ready=0 at occ≥7. Complete all in order → two retires per cycle, head wraps to 0. Allocate 2 more → tags 0,1.
- Flush with 5 busy entries plus a same-cycle completion and alloc → next cycle empty=1, wen1=wen2=0, alloc_tag0=0. A later completion to an old tag is ignored.
- Assert rst_n=0 while wen1=1 → wen1 drops asynchronously to 0. After release, empty=1 and alloc_ready=1.

Source files
------------

// File: rtl/wb_retire_unit.sv
// wb_retire_unit: in-order dual-retire writeback buffer; accepts out-of-order completions by slot tag
// and drives two register-file write ports strictly in program order.
module wb_retire_unit #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8,
  localparam int TAG_W = $clog2(DEPTH),
  localparam int OW    = TAG_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [1:0]        alloc_req,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag0,
  output logic [TAG_W-1:0]  alloc_tag1,
  input  logic              comp_valid1,
  input  logic [TAG_W-1:0]  comp_tag1,
  input  logic              comp_wr1,
  input  logic [4:0]        comp_rd1,
  input  logic [DATA_W-1:0] comp_data1,
  input  logic              comp_valid2,
  input  logic [TAG_W-1:0]  comp_tag2,
  input  logic              comp_wr2,
  input  logic [4:0]        comp_rd2,
  input  logic [DATA_W-1:0] comp_data2,
  output logic              wen1,
  output logic              wen2,
  output logic [4:0]        rd_addr1,
  output logic [4:0]        rd_addr2,
  output logic [DATA_W-1:0] write_data1,
  output logic [DATA_W-1:0] write_data2,
  output logic [1:0]        retire_cnt,
  output logic              empty
);
  logic [TAG_W-1:0]  head, tail, h1;
  logic [OW-1:0]     occ;
  logic [DEPTH-1:0]  busy, done, wr;
  logic [4:0]        rd [DEPTH];
  logic [DATA_W-1:0] data [DEPTH];
  logic              r0, r1, same, w1, w2;
  logic [1:0]        grant, rcnt;
  assign h1          = head + TAG_W'(1);
  assign alloc_ready = occ <= OW'(DEPTH - 2);
  assign alloc_tag0  = tail;
  assign alloc_tag1  = tail + TAG_W'(1);
  assign empty       = occ == '0;
  assign grant       = (alloc_ready && alloc_req != 2'd3) ? alloc_req : 2'd0;
  assign r0          = busy[head] & done[head];
  assign r1          = r0 & busy[h1] & done[h1];
  assign rcnt        = {r1, r0 & ~r1};
  // Same-destination pair: only the younger write survives
  assign same        = r1 & wr[head] & wr[h1] & (rd[head] == rd[h1]);
  assign w1          = r0 & wr[head] & (|rd[head]) & ~same;
  assign w2          = r1 & wr[h1] & (|rd[h1]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      occ <= '0;
      busy <= '0;
      done <= '0;
      wr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd[i] <= '0;
        data[i] <= '0;
      end
      wen1 <= 1'b0;
      wen2 <= 1'b0;
      rd_addr1 <= '0;
      rd_addr2 <= '0;
      write_data1 <= '0;
      write_data2 <= '0;
      retire_cnt <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      occ <= '0;
      busy <= '0;
      done <= '0;
      wen1 <= 1'b0;
      wen2 <= 1'b0;
      rd_addr1 <= '0;
      rd_addr2 <= '0;
      write_data1 <= '0;
      write_data2 <= '0;
      retire_cnt <= '0;
    end else begin
      // Lane 2 first so lane 1 overrides it on a shared tag
      if (comp_valid2 && busy[comp_tag2]) begin
        done[comp_tag2] <= 1'b1;
        wr[comp_tag2] <= comp_wr2;
        rd[comp_tag2] <= comp_rd2;
        data[comp_tag2] <= comp_data2;
      end
      if (comp_valid1 && busy[comp_tag1]) begin
        done[comp_tag1] <= 1'b1;
        wr[comp_tag1] <= comp_wr1;
        rd[comp_tag1] <= comp_rd1;
        data[comp_tag1] <= comp_data1;
      end
      if (r0) begin
        busy[head] <= 1'b0;
        done[head] <= 1'b0;
      end
      if (r1) begin
        busy[h1] <= 1'b0;
        done[h1] <= 1'b0;
      end
      if (grant != 2'd0) begin
        busy[tail] <= 1'b1;
        done[tail] <= 1'b0;
      end
      if (grant == 2'd2) begin
        busy[alloc_tag1] <= 1'b1;
        done[alloc_tag1] <= 1'b0;
      end
      head <= head + TAG_W'(rcnt);
      tail <= tail + TAG_W'(grant);
      occ <= occ + OW'(grant) - OW'(rcnt);
      wen1 <= w1;
      wen2 <= w2;
      rd_addr1 <= r0 ? rd[head] : 5'd0;
      rd_addr2 <= r1 ? rd[h1] : 5'd0;
      write_data1 <= r0 ? data[head] : '0;
      write_data2 <= r1 ? data[h1] : '0;
      retire_cnt <= rcnt;
    end
  end
endmodule

// File: tb/tb_wb_retire_unit.sv
// tb_wb_retire_unit: directed plus random stimulus against a program-order queue model of the retire buffer.
module tb_wb_retire_unit;
  localparam int DEPTH = 8;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic [1:0]  alloc_req = '0;
  logic        alloc_ready, wen1, wen2, empty;
  logic [2:0]  alloc_tag0, alloc_tag1;
  logic        comp_valid1 = 0, comp_valid2 = 0, comp_wr1 = 0, comp_wr2 = 0;
  logic [2:0]  comp_tag1 = '0, comp_tag2 = '0;
  logic [4:0]  comp_rd1 = '0, comp_rd2 = '0, rd_addr1, rd_addr2;
  logic [63:0] comp_data1 = '0, comp_data2 = '0, write_data1, write_data2;
  logic [1:0]  retire_cnt;
  int checks = 0, errors = 0;

  typedef struct {
    logic [2:0]  tag;
    bit          done;
    bit          wr;
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;
  ent_t q[$];
  int next_tag = 0;
  bit e_wen1, e_wen2;
  int e_cnt;
  logic [4:0] e_rd1, e_rd2;
  logic [63:0] e_d1, e_d2;

  wb_retire_unit #(.DATA_W(64), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .alloc_req(alloc_req),
    .alloc_ready(alloc_ready), .alloc_tag0(alloc_tag0), .alloc_tag1(alloc_tag1),
    .comp_valid1(comp_valid1), .comp_tag1(comp_tag1), .comp_wr1(comp_wr1),
    .comp_rd1(comp_rd1), .comp_data1(comp_data1),
    .comp_valid2(comp_valid2), .comp_tag2(comp_tag2), .comp_wr2(comp_wr2),
    .comp_rd2(comp_rd2), .comp_data2(comp_data2),
    .wen1(wen1), .wen2(wen2), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .write_data1(write_data1), .write_data2(write_data2),
    .retire_cnt(retire_cnt), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    next_tag = 0;
    {e_wen1, e_wen2, e_cnt, e_rd1, e_rd2, e_d1, e_d2} = '0;
  endtask

  task automatic complete(input logic [2:0] t, input bit w, input logic [4:0] r, input logic [63:0] d);
    foreach (q[i]) if (q[i].tag == t) begin
      q[i].done = 1;
      q[i].wr = w;
      q[i].rd = r;
      q[i].data = d;
    end
  endtask

  // One clock of the buffer as seen from program order, using inputs before the edge
  task automatic model_step();
    int n, g;
    if (flush) begin
      model_reset();
      return;
    end
    n = 0;
    if (q.size() > 0 && q[0].done) n = 1;
    if (n == 1 && q.size() > 1 && q[1].done) n = 2;
    e_cnt = n;
    e_wen1 = n >= 1 && q[0].wr && q[0].rd != 0;
    e_wen2 = n == 2 && q[1].wr && q[1].rd != 0;
    if (e_wen1 && e_wen2 && q[0].rd == q[1].rd) e_wen1 = 0;
    if (n >= 1) begin e_rd1 = q[0].rd; e_d1 = q[0].data; end
    if (n == 2) begin e_rd2 = q[1].rd; e_d2 = q[1].data; end
    g = (DEPTH - q.size() >= 2) ? int'(alloc_req) : 0;
    if (comp_valid2) complete(comp_tag2, comp_wr2, comp_rd2, comp_data2);
    if (comp_valid1) complete(comp_tag1, comp_wr1, comp_rd1, comp_data1);
    repeat (n) void'(q.pop_front());
    repeat (g) begin
      q.push_back('{tag: 3'(next_tag), done: 0, wr: 0, rd: '0, data: '0});
      next_tag = (next_tag + 1) % DEPTH;
    end
  endtask

  task automatic check_all();
    chk("wen1", wen1, e_wen1);
    chk("wen2", wen2, e_wen2);
    chk("retire_cnt", retire_cnt, e_cnt);
    if (e_cnt >= 1) begin chk("rd_addr1", rd_addr1, e_rd1); chk("write_data1", write_data1, e_d1); end
    if (e_cnt == 2) begin chk("rd_addr2", rd_addr2, e_rd2); chk("write_data2", write_data2, e_d2); end
    chk("empty", empty, q.size() == 0);
    chk("alloc_ready", alloc_ready, DEPTH - q.size() >= 2);
    chk("alloc_tag0", alloc_tag0, next_tag);
    chk("alloc_tag1", alloc_tag1, (next_tag + 1) % DEPTH);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    flush = 0; alloc_req = 0; comp_valid1 = 0; comp_valid2 = 0;
  endtask

  task automatic c1(input logic [2:0] t, input bit w, input logic [4:0] r, input logic [63:0] d);
    comp_valid1 = 1; comp_tag1 = t; comp_wr1 = w; comp_rd1 = r; comp_data1 = d;
  endtask

  task automatic c2(input logic [2:0] t, input bit w, input logic [4:0] r, input logic [63:0] d);
    comp_valid2 = 1; comp_tag2 = t; comp_wr2 = w; comp_rd2 = r; comp_data2 = d;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_alloc_tag1", alloc_tag1, 1);
    rst_n = 1;
    // Out-of-order completion, paired retire
    alloc_req = 2; cyc();
    chk("t1_tag1_busy_ready", alloc_ready, 1);
    c1(1, 1, 5, 64'hAA); cyc();
    c1(0, 1, 6, 64'hBB); cyc();
    chk("t1_no_early_write", wen1 | wen2, 0);
    cyc();
    chk("t1_wen1", wen1, 1); chk("t1_rd1", rd_addr1, 6); chk("t1_d1", write_data1, 64'hBB);
    chk("t1_wen2", wen2, 1); chk("t1_rd2", rd_addr2, 5); chk("t1_d2", write_data2, 64'hAA);
    chk("t1_cnt", retire_cnt, 2);
    cyc();
    chk("t1_single_pulse", wen1 | wen2, 0);
    // Same destination register
    flush = 1; cyc();
    alloc_req = 2; cyc();
    c1(0, 1, 7, 64'd1); c2(1, 1, 7, 64'd2); cyc();
    cyc();
    chk("same_wen1", wen1, 0); chk("same_wen2", wen2, 1);
    chk("same_rd2", rd_addr2, 7); chk("same_d2", write_data2, 2);
    // x0 and non-writing instructions
    alloc_req = 2; cyc();
    c1(2, 1, 0, 64'h11); c2(3, 0, 9, 64'h22); cyc();
    cyc();
    chk("x0_cnt", retire_cnt, 2); chk("x0_wen", {wen1, wen2}, 0);
    // Fill and wrap
    flush = 1; cyc();
    repeat (4) begin alloc_req = 2; cyc(); end
    chk("full_ready", alloc_ready, 0);
    alloc_req = 2; cyc();
    chk("full_no_grant_tag", alloc_tag0, 0);
    for (int i = 0; i < 8; i += 2) begin
      c1(3'(i), 1, 5'(i + 1), 64'(i + 100)); c2(3'(i + 1), 1, 5'(i + 2), 64'(i + 200)); cyc();
    end
    repeat (2) cyc();
    chk("wrap_empty", empty, 1);
    alloc_req = 2; cyc();
    chk("wrap_tag0", alloc_tag0, 2);
    // Flush with live entries, same-cycle completion and alloc
    flush = 1; cyc();
    alloc_req = 2; cyc(); alloc_req = 2; cyc(); alloc_req = 1; cyc();
    chk("flush_pre_tag0", alloc_tag0, 5);
    flush = 1; alloc_req = 2; c1(0, 1, 3, 64'h5); cyc();
    chk("flush_empty", empty, 1); chk("flush_wen", {wen1, wen2}, 0); chk("flush_tag0", alloc_tag0, 0);
    c1(3, 1, 4, 64'h9); cyc();
    cyc();
    chk("flush_stale_ignored", {wen1, wen2, empty}, 3'b001);
    // Asynchronous reset during a write pulse
    alloc_req = 1; cyc();
    c1(0, 1, 3, 64'h77); cyc();
    cyc();
    chk("arst_pre_wen1", wen1, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_wen1_drop", wen1, 0);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    #1;
    chk("arst_empty", empty, 1); chk("arst_ready", alloc_ready, 1);
    @(posedge clk);
    #1;
    // Random traffic
    for (int k = 0; k < 800; k++) begin
      alloc_req = 2'($urandom_range(2));
      flush = $urandom_range(59) == 0;
      if ($urandom_range(9) < 6)
        c1((q.size() > 0 && $urandom_range(4) != 0) ? q[$urandom_range(q.size() - 1)].tag : 3'($urandom_range(7)),
           $urandom_range(3) != 0, 5'($urandom_range(7)), {$urandom, $urandom});
      if ($urandom_range(9) < 6)
        c2((q.size() > 0 && $urandom_range(4) != 0) ? q[$urandom_range(q.size() - 1)].tag : 3'($urandom_range(7)),
           $urandom_range(3) != 0, 5'($urandom_range(7)), {$urandom, $urandom});
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
